lcd_slot_scanner: RTL and testbench

LCD_SLOT_SCANNER -- requirements
Module: lcd_slot_scanner

---
 rtl/lcd_slot_scanner_pkg.sv | 24 ++
 rtl/lcd_slot_shadow.sv | 50 +++++
 rtl/lcd_slot_scanner.sv | 157 +++++++++++++++
 tb/tb_lcd_slot_scanner.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_slot_scanner_pkg.sv
// Shared types and constants for the LCD slot scanner and its shadow store.
// Optional change detection is enabled with SCAN_CHANGE_DETECT_EN.
package lcd_slot_scanner_pkg;

  localparam int SLOT_W            = 6;
  localparam int NAME_W            = 40;
  localparam int VALUE_W           = 32;
  localparam int DEFAULT_NUM_SLOTS = 44;

  typedef enum logic [2:0] {
    ST_GAP,
    ST_PRESENT,
    ST_SETTLE,
    ST_CAPTURE,
    ST_EMIT
  } scan_state_t;

  typedef struct packed {
    logic [SLOT_W-1:0]  slot;
    logic [NAME_W-1:0]  name;
    logic [VALUE_W-1:0] value;
  } upd_rec_t;

endpackage

// File: rtl/lcd_slot_shadow.sv
// Per-slot shadow of the last emitted {valid, name, value}, used only when
// SCAN_CHANGE_DETECT_EN is defined. Slots are addressed 1..NUM_SLOTS.
module lcd_slot_shadow
  import lcd_slot_scanner_pkg::*;
#(
  parameter int NUM_SLOTS = DEFAULT_NUM_SLOTS
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [SLOT_W-1:0]  rd_slot,
  output logic               rd_valid,
  output logic [NAME_W-1:0]  rd_name,
  output logic [VALUE_W-1:0] rd_value,
  input  logic               wr_en,
  input  logic [SLOT_W-1:0]  wr_slot,
  input  logic [NAME_W-1:0]  wr_name,
  input  logic [VALUE_W-1:0] wr_value,
  input  logic               clr_en,
  input  logic [SLOT_W-1:0]  clr_slot
);

  logic [NUM_SLOTS-1:0]         valid_q;
  logic [NAME_W+VALUE_W-1:0]    data_q [NUM_SLOTS];
  logic [SLOT_W-1:0]            rd_idx;
  logic [SLOT_W-1:0]            wr_idx;
  logic [SLOT_W-1:0]            clr_idx;

  assign rd_idx  = rd_slot  - 1'b1;
  assign wr_idx  = wr_slot  - 1'b1;
  assign clr_idx = clr_slot - 1'b1;

  assign rd_valid = valid_q[rd_idx];
  assign rd_name  = data_q[rd_idx][NAME_W+VALUE_W-1:VALUE_W];
  assign rd_value = data_q[rd_idx][VALUE_W-1:0];

  // Only the valid bits need reset; stale data behind a clear bit is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clr_en) valid_q[clr_idx] <= 1'b0;
      if (wr_en)  valid_q[wr_idx]  <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) data_q[wr_idx] <= {wr_name, wr_value};
  end

endmodule

// File: rtl/lcd_slot_scanner.sv
// Sweeps display slots 1..NUM_SLOTS, samples the responder and offers update
// records to the LCD renderer. SCAN_CHANGE_DETECT_EN suppresses unchanged slots.
module lcd_slot_scanner
  import lcd_slot_scanner_pkg::*;
#(
  parameter int NUM_SLOTS     = DEFAULT_NUM_SLOTS,
  parameter int SETTLE_CYCLES = 2,
  parameter int SWEEP_GAP     = 16
) (
  input  logic               clk,
  input  logic               reset,
  output logic [SLOT_W-1:0]  display_number,
  input  logic               display_valid,
  input  logic [NAME_W-1:0]  display_name,
  input  logic [VALUE_W-1:0] display_value,
  output logic               upd_valid,
  input  logic               upd_ready,
  output logic [SLOT_W-1:0]  upd_slot,
  output logic [NAME_W-1:0]  upd_name,
  output logic [VALUE_W-1:0] upd_value,
  output logic               sweep_done,
  input  logic               freeze
);

  localparam int GAP_W = (SWEEP_GAP > 1) ? $clog2(SWEEP_GAP) : 1;
  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'(SWEEP_GAP - 1);
  localparam logic [SET_W-1:0]  SET_LAST  = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SLOT_W-1:0] LAST_SLOT = SLOT_W'(NUM_SLOTS);

  scan_state_t       state_q, state_d;
  logic [GAP_W-1:0]  gap_q, gap_d;
  logic [SET_W-1:0]  settle_q, settle_d;
  logic [SLOT_W-1:0] num_q, num_d;
  upd_rec_t          rec_q, rec_d;
  logic              valid_q, valid_d;
  logic              done_q, done_d;
  logic              advance;
  logic              emittable;

`ifdef SCAN_CHANGE_DETECT_EN
  logic               sh_valid;
  logic [NAME_W-1:0]  sh_name;
  logic [VALUE_W-1:0] sh_value;
  logic               sh_wr;
  logic               sh_clr;

  assign sh_wr  = (state_q == ST_EMIT) && upd_ready;
  assign sh_clr = (state_q == ST_CAPTURE) && !display_valid;

  lcd_slot_shadow #(.NUM_SLOTS(NUM_SLOTS)) u_shadow (
    .clk      (clk),
    .reset    (reset),
    .rd_slot  (num_q),
    .rd_valid (sh_valid),
    .rd_name  (sh_name),
    .rd_value (sh_value),
    .wr_en    (sh_wr),
    .wr_slot  (rec_q.slot),
    .wr_name  (rec_q.name),
    .wr_value (rec_q.value),
    .clr_en   (sh_clr),
    .clr_slot (num_q)
  );

  assign emittable = display_valid &&
                     (!sh_valid || (display_name != sh_name) || (display_value != sh_value));
`else
  assign emittable = display_valid;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= ST_GAP;
      gap_q    <= '0;
      settle_q <= '0;
      num_q    <= SLOT_W'(1);
      rec_q    <= '0;
      valid_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      gap_q    <= gap_d;
      settle_q <= settle_d;
      num_q    <= num_d;
      rec_q    <= rec_d;
      valid_q  <= valid_d;
      done_q   <= done_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    gap_d    = gap_q;
    settle_d = settle_q;
    num_d    = num_q;
    rec_d    = rec_q;
    valid_d  = 1'b0;
    done_d   = 1'b0;
    advance  = 1'b0;

    case (state_q)
      // Freeze only bites here, so a sweep already underway always completes.
      ST_GAP: begin
        if (!freeze) begin
          if (gap_q == GAP_LAST) begin
            gap_d   = '0;
            num_d   = SLOT_W'(1);
            state_d = ST_PRESENT;
          end else begin
            gap_d = gap_q + 1'b1;
          end
        end
      end
      ST_PRESENT: begin
        settle_d = '0;
        state_d  = (SETTLE_CYCLES == 0) ? ST_CAPTURE : ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_q == SET_LAST) state_d = ST_CAPTURE;
        else                      settle_d = settle_q + 1'b1;
      end
      ST_CAPTURE: begin
        if (emittable) begin
          rec_d   = '{slot: num_q, name: display_name, value: display_value};
          valid_d = 1'b1;
          state_d = ST_EMIT;
        end else begin
          advance = 1'b1;
        end
      end
      ST_EMIT: begin
        valid_d = !upd_ready;
        advance = upd_ready;
      end
      default: state_d = ST_GAP;
    endcase

    if (advance) begin
      if (num_q == LAST_SLOT) begin
        done_d  = 1'b1;
        state_d = ST_GAP;
      end else begin
        num_d   = num_q + 1'b1;
        state_d = ST_PRESENT;
      end
    end
  end

  assign display_number = num_q;
  assign upd_valid      = valid_q;
  assign upd_slot       = rec_q.slot;
  assign upd_name       = rec_q.name;
  assign upd_value      = rec_q.value;
  assign sweep_done     = done_q;

endmodule

// File: tb/tb_lcd_slot_scanner.sv
// Randomized self-checking bench for lcd_slot_scanner; the expected record
// stream per sweep comes from a slot-content/shadow model kept here.
module tb_lcd_slot_scanner;

  localparam int NSL  = 44;
  localparam int SET  = 2;
  localparam int GAPC = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [5:0]  display_number;
  logic        display_valid;
  logic [39:0] display_name;
  logic [31:0] display_value;
  logic        upd_valid;
  logic        upd_ready;
  logic [5:0]  upd_slot;
  logic [39:0] upd_name;
  logic [31:0] upd_value;
  logic        sweep_done;
  logic        freeze;

  lcd_slot_scanner #(.NUM_SLOTS(NSL), .SETTLE_CYCLES(SET), .SWEEP_GAP(GAPC)) dut (
    .clk            (clk),
    .reset          (reset),
    .display_number (display_number),
    .display_valid  (display_valid),
    .display_name   (display_name),
    .display_value  (display_value),
    .upd_valid      (upd_valid),
    .upd_ready      (upd_ready),
    .upd_slot       (upd_slot),
    .upd_name       (upd_name),
    .upd_value      (upd_value),
    .sweep_done     (sweep_done),
    .freeze         (freeze)
  );

  always #5 clk = ~clk;

  // Responder contents, indexed by slot number.
  bit          respValid [64];
  logic [39:0] respName  [64];
  logic [31:0] respValue [64];

  assign display_valid = respValid[display_number];
  assign display_name  = respName[display_number];
  assign display_value = respValue[display_number];

  bit          shValid [64];
  logic [39:0] shName  [64];
  logic [31:0] shValue [64];

  logic [77:0] gotQ[$];
  logic [77:0] expQ[$];
  int          expCycles;
  int          passed = 0;
  int          total  = 0;
  int          stallCount = 0;
  int          rangeErr = 0;
  int          pulseErr = 0;
  bit          randReady = 0;
  int          stallLeft = 0;
  logic [5:0]  stallSlot = '0;
  int          stallWatch = 3;

  task automatic checkOutput(input string tag, input logic [77:0] observed, input logic [77:0] expected);
    total++;
    if (observed !== expected)
      $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
    else
      passed++;
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic shadowReset();
    for (int n = 0; n < 64; n++) shValid[n] = 0;
  endtask

  // Expected records for one sweep over the current contents, plus the
  // sweep_done-to-sweep_done period when upd_ready stays high.
  task automatic buildExpected();
    bit emit;
    expQ.delete();
    expCycles = GAPC;
    for (int n = 1; n <= NSL; n++) begin
      emit = respValid[n];
`ifdef SCAN_CHANGE_DETECT_EN
      emit = emit && (!shValid[n] || shName[n] != respName[n] || shValue[n] != respValue[n]);
`endif
      if (emit) begin
        expQ.push_back({6'(n), respName[n], respValue[n]});
        shValid[n] = 1;
        shName[n]  = respName[n];
        shValue[n] = respValue[n];
        expCycles += SET + 3;
      end else begin
        expCycles += SET + 2;
      end
      if (!respValid[n]) shValid[n] = 0;
    end
  endtask

  task automatic fillAll(input bit baseValues);
    for (int n = 1; n <= NSL; n++) begin
      respValid[n] = 1;
      respName[n]  = {$urandom(), 8'($urandom())};
      respValue[n] = baseValues ? 32'h100 + 32'(n) : $urandom();
    end
  endtask

  task automatic waitSweep(output int cycles);
    cycles = 0;
    do begin
      tick();
      cycles++;
    end while (!sweep_done && cycles < 3000);
    checkOutput("sweep_done_seen", sweep_done, 1);
  endtask

  task automatic checkRecords(input string tag);
    int n;
    checkOutput({tag, "_count"}, gotQ.size(), expQ.size());
    n = (gotQ.size() < expQ.size()) ? gotQ.size() : expQ.size();
    for (int i = 0; i < n; i++) checkOutput({tag, "_rec"}, gotQ[i], expQ[i]);
    gotQ.delete();
  endtask

  task automatic applyStimulus(input int kind);
    case (kind)
      0: fillAll(1);
      1: fillAll(0);
      2: begin
        fillAll(0);
        for (int n = 1; n <= 6; n++) respValid[n] = 0;
        for (int n = 39; n <= NSL; n++) respValid[n] = 0;
      end
      default: begin
        for (int n = 1; n <= NSL; n++) begin
          respValid[n] = ($urandom_range(0, 3) != 0);
          if ($urandom_range(0, 1) == 1) respValue[n] = $urandom();
          if ($urandom_range(0, 3) == 0) respName[n] = {$urandom(), 8'($urandom())};
        end
      end
    endcase
    buildExpected();
  endtask

  // Renderer model: stalls one chosen slot for a fixed count, else ready or random.
  initial begin
    upd_ready = 1'b1;
    forever begin
      tick();
      if (stallLeft > 0 && upd_valid && upd_slot == stallSlot) begin
        upd_ready = 1'b0;
        stallLeft--;
      end else begin
        upd_ready = randReady ? 1'($urandom_range(0, 1)) : 1'b1;
      end
    end
  end

  // Monitor: logs accepted records and checks the record is held while stalled.
  initial begin
    bit prevStall = 0, prevReset = 1, prevDone = 0;
    logic [77:0] prevRec = '0;
    logic [5:0]  prevNum = '0;
    forever begin
      @(negedge clk);
      #2;
      if (display_number == 0 || display_number > NSL) rangeErr++;
      if (sweep_done && prevDone) pulseErr++;
      if (!reset && prevStall && !prevReset) begin
        checkOutput("hold_valid", upd_valid, 1);
        checkOutput("hold_rec", {upd_slot, upd_name, upd_value}, prevRec);
        checkOutput("hold_number", display_number, prevNum);
      end
      if (!reset && upd_valid && upd_ready) gotQ.push_back({upd_slot, upd_name, upd_value});
      if (!reset && upd_valid && !upd_ready && upd_slot == 6'(stallWatch)) stallCount++;
      prevStall = upd_valid && !upd_ready;
      prevRec   = {upd_slot, upd_name, upd_value};
      prevNum   = display_number;
      prevReset = reset;
      prevDone  = sweep_done;
    end
  end

  initial begin
    int cyc;
    int extraDone;
    reset  = 1'b1;
    freeze = 1'b0;
    shadowReset();
    applyStimulus(0);
    repeat (3) tick();
    checkOutput("reset_number", display_number, 1);
    checkOutput("reset_valid", upd_valid, 0);
    checkOutput("reset_done", sweep_done, 0);
    checkOutput("reset_slot", upd_slot, 0);
    checkOutput("reset_name", upd_name, 0);
    checkOutput("reset_value", upd_value, 0);
    reset = 1'b0;
    gotQ.delete();

    waitSweep(cyc);
    checkOutput("s1_period", cyc, expCycles);
    checkRecords("s1");

    buildExpected();
    waitSweep(cyc);
    checkOutput("s2_period", cyc, expCycles);
    checkRecords("s2");

    respValue[9] = 32'hDEADBEEF;
    buildExpected();
    waitSweep(cyc);
    checkOutput("s3_period", cyc, expCycles);
    checkRecords("s3");

    cyc = 0;
    do begin tick(); cyc++; end while (display_number != 1 && cyc < 100);
    checkOutput("gap_length", cyc, GAPC);

    stallCount = 0;
    stallSlot  = 6'd3;
    stallLeft  = 7;
    applyStimulus(1);
    waitSweep(cyc);
    checkOutput("stall_cycles", stallCount, 7);
    checkRecords("s4");

    randReady = 1;
    applyStimulus(2);
    waitSweep(cyc);
    checkRecords("s5");

    for (int s = 0; s < 3; s++) begin
      applyStimulus(3);
      waitSweep(cyc);
      checkRecords("rand");
    end

    randReady = 0;
    applyStimulus(1);
    cyc = 0;
    do begin tick(); cyc++; end while (display_number != 20 && cyc < 1000);
    checkOutput("reach_slot20", display_number, 20);
    freeze = 1'b1;
    waitSweep(cyc);
    checkRecords("freeze_sweep");
    tick();
    extraDone = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (sweep_done) extraDone++;
    end
    checkOutput("freeze_number", display_number, NSL);
    checkOutput("freeze_valid", upd_valid, 0);
    checkOutput("freeze_records", gotQ.size(), 0);
    checkOutput("freeze_done", extraDone, 0);
    freeze = 1'b0;
    cyc = 0;
    do begin tick(); cyc++; end while (display_number != 1 && cyc < 100);
    checkOutput("freeze_gap", cyc, GAPC);

    applyStimulus(1);
    stallSlot = 6'd12;
    stallLeft = 1000000;
    cyc = 0;
    do begin tick(); cyc++; end while (!(upd_valid && upd_slot == 6'd12) && cyc < 1000);
    checkOutput("reach_emit12", {upd_valid, upd_slot}, {1'b1, 6'd12});
    reset = 1'b1;
    tick();
    checkOutput("rst_emit_valid", upd_valid, 0);
    checkOutput("rst_emit_number", display_number, 1);
    reset = 1'b0;
    stallLeft = 0;
    gotQ.delete();
    shadowReset();
    buildExpected();
    waitSweep(cyc);
    checkOutput("s10_period", cyc, expCycles);
    checkRecords("s10");

    checkOutput("number_range", rangeErr, 0);
    checkOutput("done_pulse", pulseErr, 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
